// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles the per-master request bus and the shared memory port of
//   mem_bus_arbiter.
//   slave  modport : arbiter side (takes requests, drives the memory port)
//   master modport : requester/memory side (drives requests, sees grants/data)
//   Per-master vectors are packed with port k in slice k.
interface mem_bus_arbiter_if #(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // requester side
    logic [NPORTS-1:0]          iReq;
    logic [NPORTS-1:0]          iWrite;
    logic [NPORTS*DATA_W/8-1:0] iByteEnable;
    logic [NPORTS*ADDR_W-1:0]   iAddress;
    logic [NPORTS*DATA_W-1:0]   iWriteData;
    logic [NPORTS-1:0]          oGrant;
    logic [NPORTS-1:0]          oReadValid;
    logic [DATA_W-1:0]          oReadData;
    logic                       oBusy;
    // memory side
    logic                       oMemReadEnable;
    logic                       oMemWriteEnable;
    logic [DATA_W/8-1:0]        oMemByteEnable;
    logic [ADDR_W-1:0]          oMemAddress;
    logic [DATA_W-1:0]          oMemWriteData;
    logic [DATA_W-1:0]          iMemReadData;

    modport slave (
        input  iReq, iWrite, iByteEnable, iAddress, iWriteData, iMemReadData,
        output oGrant, oReadValid, oReadData, oBusy,
               oMemReadEnable, oMemWriteEnable, oMemByteEnable,
               oMemAddress, oMemWriteData
    );

    modport master (
        output iReq, iWrite, iByteEnable, iAddress, iWriteData, iMemReadData,
        input  oGrant, oReadValid, oReadData, oBusy,
               oMemReadEnable, oMemWriteEnable, oMemByteEnable,
               oMemAddress, oMemWriteData
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Lets NPORTS bus masters share a single memory port. One transaction at a
//   time: IDLE arbitrates and latches the winner's command, ACCESS drives the
//   memory strobe for one cycle, WAIT counts out RD_LATENCY for reads and
//   registers the returned data.
//   Ports:
//     iCLK  core clock
//     iRST  synchronous reset, active-low
//     bus   mem_bus_arbiter_if.slave: per-port iReq/iWrite/iByteEnable/
//           iAddress/iWriteData, oGrant/oReadValid/oReadData/oBusy, and the
//           memory port oMem*/iMemReadData
//   Build option:
//     ARB_FIXED_PRIORITY_EN  defined: lowest-index requester always wins;
//                            undefined: round-robin starting after the last
//                            granted port.
module mem_bus_arbiter #(
    parameter int unsigned NPORTS     = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic             iCLK,
    input  logic             iRST,
    mem_bus_arbiter_if.slave bus
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned PW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned CW   = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic [PW-1:0]     port_q,   port_d;
    logic              write_q,  write_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [NPORTS-1:0] grant_q,  grant_d;
    logic [NPORTS-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              rd_en_q,  rd_en_d;
    logic              wr_en_q,  wr_en_d;
    logic [BE_W-1:0]   be_q,     be_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;

    logic              any_req;
    logic [PW-1:0]     win;

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        win     = '0;
        any_req = |bus.iReq;
        // Descending scan so the lowest requesting index is the last write.
        for (int unsigned i = NPORTS; i > 0; i--) begin
            if (bus.iReq[i-1]) win = PW'(i - 1);
        end
    end
`else
    logic [PW-1:0] last_q, last_d;
    logic          found;

    always_comb begin
        int unsigned idx;
        win     = '0;
        found   = 1'b0;
        any_req = |bus.iReq;
        // Search last+1, last+2, ... wrapping modulo NPORTS; first hit wins.
        for (int unsigned i = 1; i <= NPORTS; i++) begin
            idx = 32'(last_q) + i;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!found && bus.iReq[idx]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        write_d  = write_q;
        cnt_d    = cnt_q;
        grant_d  = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifndef ARB_FIXED_PRIORITY_EN
        last_d   = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_ACCESS;
                    port_d       = win;
                    write_d      = bus.iWrite[win];
                    addr_d       = bus.iAddress[32'(win) * ADDR_W +: ADDR_W];
                    be_d         = bus.iByteEnable[32'(win) * BE_W +: BE_W];
                    wdata_d      = bus.iWriteData[32'(win) * DATA_W +: DATA_W];
                    grant_d[win] = 1'b1;
                    // Strobe is registered here so it coincides with the grant.
                    rd_en_d      = !bus.iWrite[win];
                    wr_en_d      = bus.iWrite[win];
`ifndef ARB_FIXED_PRIORITY_EN
                    last_d       = win;
`endif
                end
            end
            ST_ACCESS: begin
                if (write_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CW'(RD_LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d          = bus.iMemReadData;
                    rvalid_d[port_q] = 1'b1;
                    state_d          = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state_q  <= ST_IDLE;
            port_q   <= '0;
            write_q  <= 1'b0;
            cnt_q    <= '0;
            grant_q  <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            last_q   <= PW'(NPORTS - 1);
`endif
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            write_q  <= write_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifndef ARB_FIXED_PRIORITY_EN
            last_q   <= last_d;
`endif
        end
    end

    assign bus.oGrant          = grant_q;
    assign bus.oReadValid      = rvalid_q;
    assign bus.oReadData       = rdata_q;
    assign bus.oBusy           = (state_q != ST_IDLE);
    assign bus.oMemReadEnable  = rd_en_q;
    assign bus.oMemWriteEnable = wr_en_q;
    assign bus.oMemByteEnable  = be_q;
    assign bus.oMemAddress     = addr_q;
    assign bus.oMemWriteData   = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Randomised requesters against a transaction-level reference: each
//   accepted request is scheduled by cycle number (grant/strobe at g,
//   read data captured at g+LAT, valid at g+LAT+1, bus free again at g+1
//   for writes or g+LAT+1 for reads) and every output is compared each cycle.
//   Build option ARB_FIXED_PRIORITY_EN selects the fixed-priority reference.
module tb_mem_bus_arbiter;
    localparam int NP   = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 4;
    localparam int BW   = DW / 8;
    localparam int NCYC = 2500;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

    mem_bus_arbiter #(
        .NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)
    ) dut (
        .iCLK(clk),
        .iRST(rst_n),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // requester state
    bit          pend   [NP];
    bit          p_wr   [NP];
    logic [AW-1:0] p_addr [NP];
    logic [BW-1:0] p_be   [NP];
    logic [DW-1:0] p_wd   [NP];
    int          gr_cyc  = -10;
    int          gr_port = 0;

    // reference transaction schedule
    int          cur_g     = -1;
    int          cur_port  = 0;
    bit          cur_wr    = 1'b0;
    int          next_idle = 0;
    int          last      = NP - 1;
    logic [AW-1:0] e_addr  = '0;
    logic [BW-1:0] e_be    = '0;
    logic [DW-1:0] e_wd    = '0;
    logic [DW-1:0] e_rdata = '0;
    logic [DW-1:0] mem_rd;

    int          sat_q[$];

    task automatic new_req(input int p, input bit wr, input logic [AW-1:0] a,
                           input logic [BW-1:0] be, input logic [DW-1:0] wd);
        pend[p] = 1'b1; p_wr[p] = wr; p_addr[p] = a; p_be[p] = be; p_wd[p] = wd;
    endtask

    initial begin
        logic [NP-1:0] e_grant, e_rv;
        bit e_busy, e_rd, e_wr, any, sat;
        int w;

        for (int p = 0; p < NP; p++) begin
            pend[p] = 1'b0; p_wr[p] = 1'b0; p_addr[p] = '0; p_be[p] = '0; p_wd[p] = '0;
        end
        bus_if.iReq = '0; bus_if.iWrite = '0; bus_if.iByteEnable = '0;
        bus_if.iAddress = '0; bus_if.iWriteData = '0; bus_if.iMemReadData = '0;

        for (int k = 0; k < NCYC; k++) begin
            @(posedge clk);
            #1;
            // ---- compare this cycle's outputs ----
            e_grant = (cur_g == k) ? (NP'(1) << cur_port) : '0;
            e_rv    = (cur_g >= 0 && !cur_wr && k == cur_g + LAT + 1) ? (NP'(1) << cur_port) : '0;
            e_busy  = (cur_g >= 0 && k >= cur_g && k < next_idle);
            e_rd    = (cur_g == k) && !cur_wr;
            e_wr    = (cur_g == k) && cur_wr;
            check("grant",      64'(bus_if.oGrant), 64'(e_grant));
            check("read_valid", 64'(bus_if.oReadValid), 64'(e_rv));
            check("read_data",  64'(bus_if.oReadData), 64'(e_rdata));
            check("busy",       64'(bus_if.oBusy), 64'(e_busy));
            check("rd_strobe",  64'(bus_if.oMemReadEnable), 64'(e_rd));
            check("wr_strobe",  64'(bus_if.oMemWriteEnable), 64'(e_wr));
            check("strobe_excl", 64'(bus_if.oMemReadEnable & bus_if.oMemWriteEnable), 64'(0));
            check("mem_addr",   64'(bus_if.oMemAddress), 64'(e_addr));
            check("mem_be",     64'(bus_if.oMemByteEnable), 64'(e_be));
            check("mem_wdata",  64'(bus_if.oMemWriteData), 64'(e_wd));

            sat = (k >= 400 && k < 800);
            if (k >= 402 && k < 800) begin
                for (int p = 0; p < NP; p++)
                    if (bus_if.oGrant[p]) sat_q.push_back(p);
            end

            // ---- stimulus for this cycle ----
            rst_n = 1'b1;
            if (k < 2) rst_n = 1'b0;
            if (k >= 800) begin
                if (cur_g >= 0 && !cur_wr && k > cur_g && k <= cur_g + LAT
                    && $urandom_range(0, 9) == 0) rst_n = 1'b0;
                else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            end

            for (int p = 0; p < NP; p++) begin
                if (gr_cyc == k - 1 && gr_port == p) pend[p] = 1'b0;
                if (!pend[p]) begin
                    if (sat)
                        new_req(p, 1'b0, $urandom, BW'($urandom), $urandom);
                    else if ($urandom_range(0, 3) == 0)
                        new_req(p, 1'($urandom), $urandom, BW'($urandom), $urandom);
                end else if (!sat && gr_cyc != k && $urandom_range(0, 7) == 0) begin
                    pend[p] = 1'b0;   // withdrawn before grant
                end
            end
            if (k == 4  && !pend[0]) new_req(0, 1'b0, 32'h100, '1, '0);
            if (k == 30 && !pend[1]) new_req(1, 1'b1, 32'h200, BW'(4'b0011), 32'hCAFEF00D);

            mem_rd = (k < 60) ? 32'hDEADBEEF : $urandom;
            for (int p = 0; p < NP; p++) begin
                bus_if.iReq[p]                  = pend[p];
                bus_if.iWrite[p]                = p_wr[p];
                bus_if.iAddress[p*AW +: AW]     = p_addr[p];
                bus_if.iByteEnable[p*BW +: BW]  = p_be[p];
                bus_if.iWriteData[p*DW +: DW]   = p_wd[p];
            end
            bus_if.iMemReadData = mem_rd;

            // ---- reference update for the edge ending this cycle ----
            any = 1'b0;
            for (int p = 0; p < NP; p++) any |= pend[p];
            if (!rst_n) begin
                cur_g = -1; next_idle = k + 1; last = NP - 1;
                e_addr = '0; e_be = '0; e_wd = '0; e_rdata = '0;
            end else if (k >= next_idle && any) begin
                w = -1;
`ifdef ARB_FIXED_PRIORITY_EN
                for (int i = 0; i < NP; i++)
                    if (w < 0 && pend[i]) w = i;
`else
                for (int i = 1; i <= NP; i++)
                    if (w < 0 && pend[(last + i) % NP]) w = (last + i) % NP;
`endif
                cur_g = k + 1; cur_port = w; cur_wr = p_wr[w];
                e_addr = p_addr[w]; e_be = p_be[w]; e_wd = p_wd[w];
                last = w;
                next_idle = cur_wr ? k + 2 : k + LAT + 2;
                gr_cyc = k + 1; gr_port = w;
            end else if (cur_g >= 0 && !cur_wr && k == cur_g + LAT) begin
                e_rdata = mem_rd;
            end
        end

        // grants under continuous requests must rotate (or stick to port 0)
        check("sat_grants_seen", 64'(sat_q.size() >= 20), 64'(1));
        for (int i = 1; i < sat_q.size(); i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            check("sat_order", 64'(sat_q[i]), 64'(0));
`else
            check("sat_order", 64'(sat_q[i]), 64'((sat_q[i-1] + 1) % NP));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Parametrised shared-memory arbiter for the softcore. It lets NPORTS masters share one memory interface port; typical masters are instruction fetch, data access and debug/DMA. This generalises the fixed one-port-per-bus arrangement of the current cores to a single arbitrated bus with configurable read latency. It sits between the datapath bus masters and the memory interface block.

Parameters:
NPORTS, 2, number of requesting masters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width; must be a multiple of 8
RD_LATENCY, 1, cycles from the memory strobe to read data valid on iMemReadData (1..7)

Ports:
iCLK  in  1  core clock
iRST  in  1  synchronous reset, active-low
iReq  in  NPORTS  per-port request; held until the port's oGrant
iWrite  in  NPORTS  per-port command: 1=write, 0=read
iByteEnable  in  NPORTS*DATA_W/8  per-port byte enables; port k in slice k
iAddress  in  NPORTS*ADDR_W  per-port address
iWriteData  in  NPORTS*DATA_W  per-port write data
oGrant  out  NPORTS  one-cycle pulse; request accepted
oReadValid  out  NPORTS  one-cycle pulse; oReadData valid for that port
oReadData  out  DATA_W  read data, shared by all ports
oBusy  out  1  high whenever the state is not IDLE
oMemReadEnable  out  1  memory read strobe
oMemWriteEnable  out  1  memory write strobe
oMemByteEnable  out  DATA_W/8  memory byte enables
oMemAddress  out  ADDR_W  memory address
oMemWriteData  out  DATA_W  memory write data
iMemReadData  in  DATA_W  memory read data

Behaviour:
- Reset (iRST=0 at posedge):
  - state IDLE; all outputs 0; latency counter 0.
  - Round-robin pointer last = NPORTS-1, so port 0 wins first.
- Reset mid-transaction: any in-flight read is abandoned and no oReadValid is issued.
- State machine: IDLE, ACCESS, WAIT.
- IDLE:
  - If any iReq is high, select the winner by search order last+1, last+2, … modulo NPORTS.
  - At the posedge: latch the winner's command, address, byte enables and write data into the memory output registers; set oGrant[winner]=1; set last=winner; go to ACCESS.
  - If no iReq is high, stay in IDLE.
- ACCESS:
  - Exactly one cycle, with oMemReadEnable or oMemWriteEnable high per the latched command.
  - oGrant returns to 0.
  - Write: next state IDLE.
  - Read: load counter=RD_LATENCY-1 and go to WAIT.
- WAIT:
  - Strobes are 0; address, byte enables and write data hold their values.
  - When counter==0, register iMemReadData into oReadData, pulse oReadValid[latched port] for one cycle, and go to IDLE.
  - Otherwise decrement the counter.
- Timing:
  - iReq seen at cycle 0 gives grant and strobe in cycle 1.
  - Read data: if the strobe is in cycle T, iMemReadData is sampled during cycle T+RD_LATENCY and oReadValid is high in cycle T+RD_LATENCY+1.
  - Write throughput: one transaction per 2 cycles.
  - Read throughput: one transaction per RD_LATENCY+2 cycles.
- Handshake:
  - The requester holds iReq and its command stable until oGrant.
  - After the oGrant cycle it may drop iReq or present a new request.
  - A request still asserted in the oGrant cycle is treated as a new request.
- Boundaries:
  - With all ports requesting continuously, grants rotate 0,1,…,NPORTS-1,0. No port waits more than NPORTS-1 transactions.
  - iReq deasserted before grant: the request is withdrawn silently.
  - oReadData holds its last value between reads.
  - Unused strobes are always 0; read and write strobes are never high together.

Optional Feature:
ARB_FIXED_PRIORITY_EN:
- Defined: round-robin is replaced by fixed priority. The lowest-index requesting port always wins, and the pointer is unused.
- Undefined: round-robin as above.
All timing is otherwise identical.

Test Plan:
- NPORTS=2, RD_LATENCY=1. Port0 reads 0x100 at cycle 0, memory returns 0xDEADBEEF. Required: oGrant[0] in cycle 1, oMemReadEnable in cycle 1, oReadValid[0]=1 with oReadData=0xDEADBEEF in cycle 3.
- Port1 writes 0xCAFEF00D to 0x200 with byte enables 0b0011. Required: oMemWriteEnable=1, oMemAddress=0x200, oMemByteEnable=0011 for exactly one cycle; no oReadValid.
- NPORTS=3, all ports request reads continuously. Required grant order 0,1,2,0,1,2, and oReadValid goes to the matching port each time. With ARB_FIXED_PRIORITY_EN: port 0 is granted every transaction.
- RD_LATENCY=4, read with the strobe at cycle T. Required: oReadValid at T+5; oBusy high from T through T+4; no strobe during WAIT.
- iRST=0 asserted during WAIT. Required: next cycle all outputs 0, no oReadValid; a subsequent port-0 read completes normally.
- Port0 raises iReq, then drops it while port1 is being serviced. Required: port0 is never granted and no spurious strobe occurs.
